// File: rtl/cpu_display_driver.sv
// cpu_display_driver: scans a snapshotted CPU debug value pair onto a 4-digit
// seven-segment display and debounces the manual step button into the CPU clock.
module cpu_display_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  view_sel,
  input  logic        btn_raw,
  input  logic [31:0] IF_InsAddr,
  input  logic [31:0] IF_nextPC,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [31:0] EXE_updateDataA,
  input  logic [31:0] EXE_updateDataB,
  input  logic [31:0] EXE_ALUData,
  input  logic [31:0] WB_DBData,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        step_level,
  output logic        step_pulse
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          level_q, level_d, level_prev_q, pulse_q;
  logic          wrap, mismatch, deb_done;
  logic [7:0]    a_sel, b_sel;
  logic [3:0]    nib;
  logic          unused_bits;
  assign unused_bits = ^{IF_InsAddr[31:8], IF_nextPC[31:8], EXE_updateDataA[31:8],
                         EXE_updateDataB[31:8], EXE_ALUData[31:8], WB_DBData[31:8]};
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction
  always_comb begin
    a_sel    = view_sel == 2'd0 ? IF_InsAddr[7:0] :
               view_sel == 2'd1 ? {3'b000, ID_rs} :
               view_sel == 2'd2 ? {3'b000, ID_rt} : EXE_ALUData[7:0];
    b_sel    = view_sel == 2'd0 ? IF_nextPC[7:0] :
               view_sel == 2'd1 ? EXE_updateDataA[7:0] :
               view_sel == 2'd2 ? EXE_updateDataB[7:0] : WB_DBData[7:0];
    wrap     = scan_q == SW'(SCAN_DIV - 1);
    scan_d   = wrap ? '0 : scan_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    // Snapshot only at frame start so a frame never mixes old and new values
    snap_d   = (scan_q == '0 && idx_q == 2'd0) ? {a_sel, b_sel} : snap_q;
    nib      = snap_q[{idx_q, 2'b00} +: 4];
    an_d     = ~(4'b0001 << idx_q);
    seg_d    = hex7(nib);
    mismatch = sync2_q != level_q;
    deb_done = mismatch && deb_q == DW'(DEBOUNCE_CNT - 1);
    deb_d    = (!mismatch || deb_done) ? '0 : deb_q + 1'b1;
    level_d  = deb_done ? ~level_q : level_q;
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      scan_q       <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign step_level = level_q;
  assign step_pulse = pulse_q;
endmodule

// File: tb/tb_cpu_display_driver.sv
// tb_cpu_display_driver: directed checks of scanning, snapshotting, hex
// encoding, button debounce and asynchronous reset.
module tb_cpu_display_driver;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  view_sel;
  logic        btn_raw;
  logic [31:0] IF_InsAddr, IF_nextPC, EXE_updateDataA, EXE_updateDataB, EXE_ALUData, WB_DBData;
  logic [4:0]  ID_rs, ID_rt;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        step_level, step_pulse;
  int          checks = 0;
  int          errors = 0;
  cpu_display_driver #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .CLK(CLK), .Reset(Reset), .view_sel(view_sel), .btn_raw(btn_raw),
    .IF_InsAddr(IF_InsAddr), .IF_nextPC(IF_nextPC), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EXE_updateDataA(EXE_updateDataA), .EXE_updateDataB(EXE_updateDataB),
    .EXE_ALUData(EXE_ALUData), .WB_DBData(WB_DBData),
    .an(an), .seg(seg), .step_level(step_level), .step_pulse(step_pulse)
  );
  always #5 CLK = ~CLK;
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_digit(input string tag, input logic [3:0] e_an, input logic [7:0] e_seg);
    chk({tag, "_an"}, {28'd0, an}, {28'd0, e_an});
    chk({tag, "_seg"}, {24'd0, seg}, {24'd0, e_seg});
  endtask
  initial begin
    Reset = 1'b0; view_sel = 2'd0; btn_raw = 1'b0;
    IF_InsAddr = 32'h14; IF_nextPC = 32'h18; ID_rs = 5'd0; ID_rt = 5'd0;
    EXE_updateDataA = 32'd0; EXE_updateDataB = 32'd0; EXE_ALUData = 32'd0; WB_DBData = 32'd0;
    step(3);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_level", {31'd0, step_level}, 32'd0);
    chk("rst_pulse", {31'd0, step_pulse}, 32'd0);
    Reset = 1'b1;
    step(1);
    chk("first_an", {28'd0, an}, 32'hE);
    step(1);  chk_digit("v0_d0", 4'b1110, 8'h80);
    step(3);  chk_digit("v0_d1", 4'b1101, 8'hF9);
    step(4);  chk_digit("v0_d2", 4'b1011, 8'h99);
    IF_nextPC = 32'hAF;
    step(4);  chk_digit("v0_d3", 4'b0111, 8'hF9);
    step(5);  chk_digit("tear_d0", 4'b1110, 8'h8E);
    step(3);  chk_digit("tear_d1", 4'b1101, 8'h88);
    view_sel = 2'd1; ID_rs = 5'h1F; EXE_updateDataA = 32'h1234_56C3;
    step(4);  chk_digit("hold_d2", 4'b1011, 8'h99);
    step(4);  chk_digit("hold_d3", 4'b0111, 8'hF9);
    step(5);  chk_digit("v1_d0", 4'b1110, 8'hB0);
    step(3);  chk_digit("v1_d1", 4'b1101, 8'hC6);
    step(4);  chk_digit("v1_d2", 4'b1011, 8'h8E);
    step(4);  chk_digit("v1_d3", 4'b0111, 8'hF9);
    view_sel = 2'd3; EXE_ALUData = 32'hFFFF_FF6E; WB_DBData = 32'h0000_00D9;
    step(5);  chk_digit("v3_d0", 4'b1110, 8'h90);
    step(3);  chk_digit("v3_d1", 4'b1101, 8'hA1);
    step(4);  chk_digit("v3_d2", 4'b1011, 8'h86);
    step(4);  chk_digit("v3_d3", 4'b0111, 8'h82);
    view_sel = 2'd2; ID_rt = 5'h12; EXE_updateDataB = 32'h0000_007B;
    step(5);  chk_digit("v2_d0", 4'b1110, 8'h83);
    step(3);  chk_digit("v2_d1", 4'b1101, 8'hF8);
    step(4);  chk_digit("v2_d2", 4'b1011, 8'hA4);
    step(4);  chk_digit("v2_d3", 4'b0111, 8'hF9);
    btn_raw = 1'b1;
    step(5);
    btn_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("glitch_level", {31'd0, step_level}, 32'd0);
      chk("glitch_pulse", {31'd0, step_pulse}, 32'd0);
    end
    btn_raw = 1'b1;
    step(9);  chk("press_early", {31'd0, step_level}, 32'd0);
    step(1);  chk("press_level", {31'd0, step_level}, 32'd1);
              chk("press_nopulse", {31'd0, step_pulse}, 32'd0);
    step(1);  chk("press_pulse", {31'd0, step_pulse}, 32'd1);
    step(1);  chk("press_pulse_end", {31'd0, step_pulse}, 32'd0);
    step(10); chk("press_held", {31'd0, step_level}, 32'd1);
    btn_raw = 1'b0;
    step(9);  chk("rel_early", {31'd0, step_level}, 32'd1);
              chk("rel_pulse0", {31'd0, step_pulse}, 32'd0);
    step(1);  chk("rel_level", {31'd0, step_level}, 32'd0);
              chk("rel_pulse1", {31'd0, step_pulse}, 32'd0);
    step(1);  chk("rel_pulse2", {31'd0, step_pulse}, 32'd0);
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    step(5);
    btn_raw = 1'b1;
    step(4);  chk("mid_an", {28'd0, an}, 32'hB);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
    chk("mid_rst_level", {31'd0, step_level}, 32'd0);
    chk("mid_rst_pulse", {31'd0, step_pulse}, 32'd0);
    step(1);
    Reset = 1'b1;
    step(1);  chk("restart_an", {28'd0, an}, 32'hE);
    step(1);  chk_digit("restart_d0", 4'b1110, 8'h83);
    step(7);  chk("fresh_deb_early", {31'd0, step_level}, 32'd0);
    step(1);  chk("fresh_deb_level", {31'd0, step_level}, 32'd1);
    step(1);  chk("fresh_deb_pulse", {31'd0, step_pulse}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
